// File: rtl/i2s_receiver_pkg.sv
// Shared definitions for the I2S receiver: default sample width, FSM encoding and error-counter helper.
package i2s_receiver_pkg;

    localparam int SAMPLE_WIDTH = 24;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        SHIFT     = 2'd1,
        HOLD      = 2'd2
    } rx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/i2s_rx_sync.sv
// Synchronises the asynchronous SCLK/LRCLK/DIN inputs into clk48m and flags SCLK rising edges.
module i2s_rx_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk48m,
    input  logic rst,
    input  logic sclk,
    input  logic lrclk,
    input  logic din,
    output logic sclk_rise,
    output logic lr_s,
    output logic din_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] lr_sync;
    logic [SYNC_STAGES-1:0] din_sync;
    logic                   sclk_d;

    // Synchroniser chains plus a registered edge detect; lr/din stay aligned with the rise flag.
    always_ff @(posedge clk48m) begin
        if (rst) begin
            sclk_sync <= '0;
            lr_sync   <= '0;
            din_sync  <= '0;
            sclk_d    <= 1'b0;
            sclk_rise <= 1'b0;
            lr_s      <= 1'b0;
            din_s     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk};
            din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
            sclk_d    <= sclk_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
            lr_s      <= lr_sync[SYNC_STAGES-1];
            din_s     <= din_sync[SYNC_STAGES-1];
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// I2S (Philips) slave receiver: deserialises stereo WIDTH-bit samples from oversampled SCLK/LRCLK/DIN.
// Optional short-slot detection and counting is enabled by defining I2S_RX_FRAME_CHECK_EN.
module i2s_receiver
    import i2s_receiver_pkg::*;
#(
    parameter int WIDTH          = SAMPLE_WIDTH,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk48m,
    input  logic             rst,
    input  logic             sclk,
    input  logic             lrclk,
    input  logic             din,
    output logic [WIDTH-1:0] left,
    output logic [WIDTH-1:0] right,
    output logic             sample_valid,
    output logic             locked,
    output logic             frame_err,
    output logic [7:0]       err_count
);

    localparam int BW    = $clog2(WIDTH + 1);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             sclk_rise;
    logic             lr_s;
    logic             din_s;

    rx_state_t        state_r;
    rx_state_t        next_state_s;
    logic [WIDTH-2:0] sr_r;
    logic [BW-1:0]    bit_cnt_r;
    logic             ch_r;
    logic             lr_prev_r;
    logic             prev_valid_r;
    logic [CNT_W-1:0] to_cnt_r;

    logic [WIDTH-1:0] shifted_s;
    logic             shift_en_s;
    logic             commit_s;
    logic             start_s;
    logic             timeout_s;
    logic [WIDTH-1:0] left_d_s;
    logic [WIDTH-1:0] right_d_s;
    logic             valid_d_s;
    logic             locked_d_s;

    i2s_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk48m    (clk48m),
        .rst       (rst),
        .sclk      (sclk),
        .lrclk     (lrclk),
        .din       (din),
        .sclk_rise (sclk_rise),
        .lr_s      (lr_s),
        .din_s     (din_s)
    );

    // Per-edge event decode. Lr history is only trusted after one edge has loaded it, and from
    // SYNC_WAIT only a move into the left slot opens a word so every pair starts with a fresh left.
    always_comb begin
        shifted_s  = {sr_r, din_s};
        shift_en_s = sclk_rise && (state_r == SHIFT);
        commit_s   = shift_en_s && (bit_cnt_r == BW'(WIDTH - 1));
        start_s    = sclk_rise && prev_valid_r && (lr_s != lr_prev_r) &&
                     ((state_r != SYNC_WAIT) || !lr_s);
        timeout_s  = !sclk_rise && (to_cnt_r == CNT_W'(TIMEOUT_CYCLES));
    end

    // FSM state register.
    always_ff @(posedge clk48m) begin
        if (rst) begin
            state_r <= SYNC_WAIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next state; the slot transition outranks the commit made on the same edge.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            SYNC_WAIT: next_state_s = start_s ? SHIFT : SYNC_WAIT;
            SHIFT: begin
                if (start_s) begin
                    next_state_s = SHIFT;
                end else if (commit_s) begin
                    next_state_s = HOLD;
                end else begin
                    next_state_s = SHIFT;
                end
            end
            HOLD:      next_state_s = start_s ? SHIFT : HOLD;
            default:   next_state_s = SYNC_WAIT;
        endcase
        if (timeout_s) begin
            next_state_s = SYNC_WAIT;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // FSM outputs: next values of the registered sample/strobe/lock outputs.
    always_comb begin
        left_d_s   = left;
        right_d_s  = right;
        valid_d_s  = 1'b0;
        locked_d_s = locked;
        if (commit_s) begin
            if (ch_r) begin
                right_d_s  = shifted_s;
                valid_d_s  = 1'b1;
                locked_d_s = 1'b1;
            end else begin
                left_d_s = shifted_s;
            end
        end else if (timeout_s) begin
            locked_d_s = 1'b0;
        end else begin
            locked_d_s = locked;
        end
    end

    // Shifter, slot tracking and SCLK-activity timeout.
    always_ff @(posedge clk48m) begin
        if (rst) begin
            sr_r         <= '0;
            bit_cnt_r    <= '0;
            ch_r         <= 1'b0;
            lr_prev_r    <= 1'b0;
            prev_valid_r <= 1'b0;
            to_cnt_r     <= '0;
        end else begin
            if (sclk_rise) begin
                to_cnt_r     <= '0;
                lr_prev_r    <= lr_s;
                prev_valid_r <= 1'b1;
            end else if (to_cnt_r != CNT_W'(TIMEOUT_CYCLES)) begin
                to_cnt_r <= to_cnt_r + CNT_W'(1);
            end
            if (start_s) begin
                ch_r      <= lr_s;
                bit_cnt_r <= '0;
                sr_r      <= '0;
            end else if (shift_en_s) begin
                sr_r      <= shifted_s[WIDTH-2:0];
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end
        end
    end

    // Registered sample outputs.
    always_ff @(posedge clk48m) begin
        if (rst) begin
            left         <= '0;
            right        <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
        end else begin
            left         <= left_d_s;
            right        <= right_d_s;
            sample_valid <= valid_d_s;
            locked       <= locked_d_s;
        end
    end

`ifdef I2S_RX_FRAME_CHECK_EN
    logic short_s;

    // A slot boundary that arrives while still shifting, without a commit, means a short word.
    always_comb begin
        short_s = start_s && (state_r == SHIFT) && !commit_s;
    end

    // Short-slot strobe and saturating counter.
    always_ff @(posedge clk48m) begin
        if (rst) begin
            frame_err <= 1'b0;
            err_count <= 8'd0;
        end else begin
            frame_err <= short_s;
            err_count <= short_s ? sat_inc8(err_count) : err_count;
        end
    end
`else
    assign frame_err = 1'b0;
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_i2s_receiver.sv
// Self-checking bench for i2s_receiver: frame table plus hand-written corner sequences, scoreboarded pairs.
module tb_i2s_receiver;

    localparam int W    = 24;
    localparam int HALF = 8;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
        int           bits;
    } frame_t;

    logic         clk48m = 1'b0;
    logic         rst    = 1'b1;
    logic         sclk   = 1'b0;
    logic         lrclk  = 1'b0;
    logic         din    = 1'b0;
    logic [W-1:0] left;
    logic [W-1:0] right;
    logic         sample_valid;
    logic         locked;
    logic         frame_err;
    logic [7:0]   err_count;

    int           checks     = 0;
    int           failures   = 0;
    int           err_pulses = 0;
    logic         prev_bit   = 1'b0;
    logic [2*W-1:0] sb[$];
    frame_t       tbl[5];

    always #10 clk48m = ~clk48m;

    i2s_receiver dut (
        .clk48m       (clk48m),
        .rst          (rst),
        .sclk         (sclk),
        .lrclk        (lrclk),
        .din          (din),
        .left         (left),
        .right        (right),
        .sample_valid (sample_valid),
        .locked       (locked),
        .frame_err    (frame_err),
        .err_count    (err_count)
    );

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard: each strobe pops the oldest expected pair.
    always @(negedge clk48m) begin
        if (!rst && frame_err) err_pulses++;
        if (!rst && sample_valid) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid actual=%h required=none", {left, right});
            end else begin
                logic [2*W-1:0] exp;
                exp = sb.pop_front();
                if ({left, right} !== exp) begin
                    failures++;
                    $display("FAIL pair actual=%h required=%h", {left, right}, exp);
                end
            end
        end
    end

    task automatic send_bit(input logic lr, input logic d);
        sclk  = 1'b0;
        lrclk = lr;
        din   = d;
        repeat (HALF) @(negedge clk48m);
        sclk = 1'b1;
        repeat (HALF) @(negedge clk48m);
    endtask

    // One slot: period 0 carries the previous slot's last bit, then the word MSB first, zero padded.
    task automatic send_slot(input logic lr, input logic [W-1:0] word, input int nbits, input int start);
        logic d;
        for (int i = start; i < nbits; i++) begin
            if (i == 0) d = prev_bit;
            else d = (i - 1 < W) ? word[W-i] : 1'b0;
            send_bit(lr, d);
        end
        prev_bit = (nbits - 1 < W) ? word[W-nbits] : 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_left"}, 48'(left), 48'h0);
        check({tag, "_right"}, 48'(right), 48'h0);
        check({tag, "_valid"}, 48'(sample_valid), 48'h0);
        check({tag, "_locked"}, 48'(locked), 48'h0);
        check({tag, "_frame_err"}, 48'(frame_err), 48'h0);
        check({tag, "_err_count"}, 48'(err_count), 48'h0);
    endtask

    initial begin
        int cyc;
        tbl[0] = '{24'h123456, 24'hABCDEF, 32};
        tbl[1] = '{24'h800001, 24'h7FFFFF, 24};
        tbl[2] = '{24'h000000, 24'hFFFFFF, 32};
        tbl[3] = '{24'h5A5A5A, 24'hA5A5A5, 24};
        tbl[4] = '{24'hFFFFFF, 24'h000001, 28};

        repeat (4) @(negedge clk48m);
        check_all_zero("reset");
        rst = 1'b0;

        // Stream joins mid left slot: the partial word and the following right are dropped.
        send_slot(1'b0, 24'h0BAD00, 32, 10);
        send_slot(1'b1, 24'h0BAD11, 32, 0);
        sb.push_back({24'h123456, 24'hABCDEF});
        send_slot(1'b0, 24'h123456, 32, 0);
        send_slot(1'b1, 24'hABCDEF, 32, 0);

        for (int k = 0; k < 5; k++) begin
            sb.push_back({tbl[k].l, tbl[k].r});
            send_slot(1'b0, tbl[k].l, tbl[k].bits, 0);
            send_slot(1'b1, tbl[k].r, tbl[k].bits, 0);
        end
        check("locked_after_frames", 48'(locked), 48'h1);

        // Short right slot of 16 bits, then a full frame.
        send_slot(1'b0, 24'h13579B, 32, 0);
        check("no_err_full_slots", 48'(err_pulses), 48'h0);
        send_slot(1'b1, 24'h2468AC, 16, 0);
        sb.push_back({24'h0F0F0F, 24'hF0F0F0});
        send_slot(1'b0, 24'h0F0F0F, 32, 0);
        send_slot(1'b1, 24'hF0F0F0, 32, 0);
        send_slot(1'b0, 24'h3C3C3C, 32, 0);
`ifdef I2S_RX_FRAME_CHECK_EN
        check("short_err_pulses", 48'(err_pulses), 48'h1);
        check("short_err_count", 48'(err_count), 48'h1);
`else
        check("short_err_pulses", 48'(err_pulses), 48'h0);
        check("short_err_count", 48'(err_count), 48'h0);
`endif

        // SCLK stops for 5000 cycles.
        check("locked_before_stop", 48'(locked), 48'h1);
        sclk = 1'b0;
        cyc = 0;
        while (locked && cyc < 6000) begin
            @(negedge clk48m);
            cyc++;
        end
        checks++;
        if (cyc < 4050 || cyc > 4150) begin
            failures++;
            $display("FAIL timeout_cycles actual=%0d required=4050..4150", cyc);
        end
        if (cyc < 5000) repeat (5000 - cyc) @(negedge clk48m);
        check("timeout_locked", 48'(locked), 48'h0);
        check("timeout_left_kept", 48'(left), 48'h3C3C3C);
        check("timeout_right_kept", 48'(right), 48'hF0F0F0);
        send_slot(1'b0, 24'h111111, 32, 0);
        send_slot(1'b1, 24'h222222, 32, 0);
        sb.push_back({24'h2B2B2B, 24'hD4D4D4});
        send_slot(1'b0, 24'h2B2B2B, 32, 0);
        send_slot(1'b1, 24'hD4D4D4, 32, 0);
        send_slot(1'b0, 24'h445566, 32, 0);
        check("relocked", 48'(locked), 48'h1);

        // Reset one cycle at bit 12 of a right word.
        send_slot(1'b1, 24'h99AABB, 12, 0);
        @(negedge clk48m);
        rst = 1'b1;
        @(negedge clk48m);
        rst = 1'b0;
        check_all_zero("midreset");
        send_slot(1'b1, 24'h99AABB, 32, 12);
        sb.push_back({24'h778899, 24'h99AABB});
        send_slot(1'b0, 24'h778899, 32, 0);
        send_slot(1'b1, 24'h99AABB, 32, 0);
        send_slot(1'b0, 24'h000000, 32, 0);
        check("locked_after_reset", 48'(locked), 48'h1);
        check("left_after_reset", 48'(left), 48'h000000);
        check("right_after_reset", 48'(right), 48'h99AABB);
        check("scoreboard_empty", 48'(sb.size()), 48'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
